serial_subtractor: RTL and testbench

//   Bit-serial W-bit subtractor computing diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor (diff = a - b), LSB first.
// Operands load in parallel on an accepted start; the result returns in
// parallel with a one-cycle done pulse, W+1 edges per operation.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the signed overflow flag;
// without it ovf is tied to 0 and no operand-MSB capture logic is built.

// Single-bit difference/borrow cell.
module serial_sub_cell (
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic d,
  output logic br_n
);
  assign d    = ai ^ bi ^ br;
  assign br_n = (~ai & bi) | (~(ai ^ bi) & br);
endmodule

module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t         state_q, state_d;
  // a_q doubles as the result register: difference bits enter at the MSB
  // as minuend bits leave at the LSB.
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic           d_bit, br_nxt;
  logic           accept, last;

  serial_sub_cell u_cell (
    .ai   (a_q[0]),
    .bi   (b_q[0]),
    .br   (br_q),
    .d    (d_bit),
    .br_n (br_nxt)
  );

  assign accept = start && (state_q != S_SHIFT);
  assign last   = (state_q == S_SHIFT) && (cnt_q == CW'(W-1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      a_d    = a;
      b_d    = b;
      br_d   = 1'b0;
      cnt_d  = '0;
      diff_d = '0;
      bout_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      a_d   = {d_bit, a_q[W-1:1]};
      b_d   = {1'b0, b_q[W-1:1]};
      br_d  = br_nxt;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        diff_d = {d_bit, a_q[W-1:1]};
        bout_d = br_nxt;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;

  // Signed overflow: operand signs differ and the result sign differs from a.
  always_comb begin
    am_d  = am_q;
    bm_d  = bm_q;
    ovf_d = ovf_q;
    if (accept) begin
      am_d  = a[W-1];
      bm_d  = b[W-1];
      ovf_d = 1'b0;
    end else if (last) begin
      ovf_d = (am_q ^ bm_q) & (d_bit ^ am_q);
    end
  end

  // Overflow flag and captured operand sign bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (W=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  localparam int W = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 with diff=%0d, expected no pending result", diff);
      end else begin
        e = sb.pop_front();
        chk("diff", diff, e.d);
        chk("bout", bout, e.bo);
        chk("ovf",  ovf,  e.ov);
      end
    end
  end

  // One isolated operation: checks clear-on-accept, done latency and busy length.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic [W-1:0] d_e, input logic bo_e, input logic ov_e,
                    input string nm);
    int n, bc;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    push(d_e, bo_e, ov_e);
    n = 0; bc = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (n == 1) begin
        start = 1'b0;
        chk({nm, "_clr"}, {bout, diff}, 0);
      end
    end while (!done && n < 40);
    chk({nm, "_lat"}, n, 9);
    chk({nm, "_busy"}, bc, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dc;
    start = 1'b0; a = '0; b = '0; rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf",  ovf,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, borrow and signed-overflow cases
    op(8'd100, 8'd37, 8'd63,  1'b0, 1'b0,   "t2");
    op(8'd5,   8'd9,  8'd252, 1'b1, 1'b0,   "t3a");
    op(8'h80,  8'h01, 8'h7F,  1'b0, OVF_ON, "t3b");
    op(8'd42,  8'd42, 8'd0,   1'b0, 1'b0,   "eq");
    op(8'd77,  8'd0,  8'd77,  1'b0, 1'b0,   "bz");
    op(8'd0,   8'hFF, 8'd1,   1'b1, 1'b0,   "max");

    // Result held after the done pulse
    @(negedge clk);
    @(negedge clk);
    chk("hold_done", done, 0);
    chk("hold_diff", diff, 1);
    chk("hold_bout", bout, 1);

    // Back-to-back: start held high, second operands in the DONE cycle
    @(negedge clk);
    a = 8'd200; b = 8'd55; start = 1'b1;
    push(8'd145, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    chk("t4_lat", n, 9);
    a = 8'd7; b = 8'd7;
    push(8'd0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end while (!done && n < 40);
    chk("t4_gap", n, 9);

    // Start while busy is ignored
    @(negedge clk);
    a = 8'd100; b = 8'd37; start = 1'b1;
    push(8'd63, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 4;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("t5_lat", n, 9);

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    a = 8'd100; b = 8'd37; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_diff", diff, 0);
    chk("t6_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("t6_nodone", dc, 0);
    op(8'd0, 8'd1, 8'd255, 1'b1, 1'b0, "t6b");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
